// File: rtl/pwm_capture_array.sv
// pwm_capture_array
//   Measures the high time of NUM_CH hobby-receiver PWM lines and converts
//   each accepted pulse into an OUT_WIDTH-bit result.
//   - A high time of MIN_TICKS or less maps to 0.
//   - Each tick above MIN_TICKS adds 1, saturating at full scale.
//   - Pulses that are too short (glitches) or stuck high (aborts) are dropped.
//   - A channel that goes TIMEOUT_TICKS without an accepted pulse falls back
//     to FAILSAFE_VALUE.
//
// Ports
//   sys_clk   in   sole clock, rising edge
//   sys_rst   in   asynchronous active-high reset
//   pwm_in    in   [NUM_CH]            raw PWM lines, asynchronous to sys_clk
//   pwm_out   out  [NUM_CH*OUT_WIDTH]  results, channel n at [n*OUT_WIDTH +: OUT_WIDTH]
//   update    out  [NUM_CH]            one-cycle strobe when a slice loads a measurement
//   ch_valid  out  [NUM_CH]            channel has a recent accepted pulse
//   failsafe  out                      any channel not valid
//
// Channel FSM
//   state      | meaning
//   WAIT_LOW   | line must be seen low before a pulse may be measured
//   ARMED      | line low, waiting for a rising edge
//   HIGH       | line high, counting ticks
module pwm_capture_array #(
  parameter int NUM_CH        = 4,
  parameter int OUT_WIDTH     = 8,
  parameter int TICK_DIV      = 208,
  parameter int GLITCH_TICKS  = 64,
  parameter int MIN_TICKS     = 256,
  parameter int MAX_TICKS     = 512,
  parameter int ABORT_TICKS   = 1024,
  parameter int TIMEOUT_TICKS = 6400,
  parameter logic [OUT_WIDTH-1:0] FAILSAFE_VALUE = '0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_CH-1:0]           pwm_in,
  output logic [NUM_CH*OUT_WIDTH-1:0] pwm_out,
  output logic [NUM_CH-1:0]           update,
  output logic [NUM_CH-1:0]           ch_valid,
  output logic                        failsafe
);

  localparam int PD_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HC_W = $clog2(ABORT_TICKS + 1);
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [PD_W-1:0] PRESC_LAST = PD_W'(TICK_DIV - 1);
  localparam logic [HC_W-1:0] GLITCH_C   = HC_W'(GLITCH_TICKS);
  localparam logic [HC_W-1:0] MIN_C      = HC_W'(MIN_TICKS);
  localparam logic [HC_W-1:0] ABORT_LAST = HC_W'(ABORT_TICKS - 1);
  localparam logic [TO_W-1:0] TIMEOUT_C  = TO_W'(TIMEOUT_TICKS);
  localparam logic [31:0]     OUT_MAX32  = (32'd1 << OUT_WIDTH) - 32'd1;

  // Full scale is nominally reached at MAX_TICKS; the thresholds must be ordered.
  if ((MAX_TICKS <= MIN_TICKS) || (ABORT_TICKS <= MAX_TICKS) ||
      (GLITCH_TICKS > MIN_TICKS)) begin : g_bad_thresholds
    $error("pwm_capture_array: tick thresholds out of order");
  end

  typedef enum logic [1:0] {
    S_WAIT_LOW = 2'd0,
    S_ARMED    = 2'd1,
    S_HIGH     = 2'd2
  } state_t;

  // Input synchronizers, delayed copy for edge detection.
  logic [NUM_CH-1:0] r_sync1, r_sync2, r_sync_d;
  // Fills with ones after reset; the FSMs ignore the synchronizer until all
  // three stages hold real input samples, so a line that is high at reset
  // release is never mistaken for a fresh rising edge.
  logic [2:0]        r_sync_fill;
  logic              w_sync_ok;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync_d    <= '0;
      r_sync_fill <= '0;
    end else begin
      r_sync1     <= pwm_in;
      r_sync2     <= r_sync1;
      r_sync_d    <= r_sync2;
      r_sync_fill <= {r_sync_fill[1:0], 1'b1};
    end
  end

  assign w_sync_ok = r_sync_fill[2];

  // Shared measurement tick.
  logic [PD_W-1:0] r_presc;
  logic            w_tick;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                r_state, w_next;
    logic [HC_W-1:0]       r_high_cnt, w_high_cnt_nxt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [OUT_WIDTH-1:0]  r_out, w_result;
    logic                  r_upd, r_valid;
    logic                  w_rise, w_fall, w_accept, w_timeout;
    logic [31:0]           w_diff;

    assign w_rise    = r_sync2[i] & ~r_sync_d[i];
    assign w_fall    = ~r_sync2[i] & r_sync_d[i];
    assign w_timeout = (r_to_cnt == TIMEOUT_C);
    assign w_diff    = 32'(r_high_cnt - MIN_C);

    always_comb begin
      w_next         = r_state;
      w_high_cnt_nxt = r_high_cnt;
      w_accept       = 1'b0;
      case (r_state)
        S_WAIT_LOW: begin
          if (w_sync_ok && !r_sync2[i]) w_next = S_ARMED;
        end
        S_ARMED: begin
          if (w_rise) begin
            w_next         = S_HIGH;
            w_high_cnt_nxt = '0;
          end
        end
        S_HIGH: begin
          // The falling edge takes priority: a tick in the same cycle is not counted.
          if (w_fall) begin
            w_next   = S_ARMED;
            w_accept = (r_high_cnt >= GLITCH_C);
          end else if (w_tick) begin
            w_high_cnt_nxt = r_high_cnt + 1'b1;
            if (r_high_cnt == ABORT_LAST) w_next = S_WAIT_LOW;
          end
        end
        default: w_next = S_WAIT_LOW;
      endcase
    end

    always_comb begin
      w_result = '0;
      if (r_high_cnt <= MIN_C) begin
        w_result = '0;
      end else if (w_diff > OUT_MAX32) begin
        w_result = '1;
      end else begin
        w_result = w_diff[OUT_WIDTH-1:0];
      end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        r_state    <= S_WAIT_LOW;
        r_high_cnt <= '0;
      end else begin
        r_state    <= w_next;
        r_high_cnt <= w_high_cnt_nxt;
      end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        r_to_cnt <= '0;
      end else if (w_accept) begin
        r_to_cnt <= '0;
      end else if (w_tick && !w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end

    // Accept outranks timeout when both land in the same cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        r_out   <= FAILSAFE_VALUE;
        r_upd   <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_upd <= w_accept;
        if (w_accept) begin
          r_out   <= w_result;
          r_valid <= 1'b1;
        end else if (w_timeout) begin
          r_out   <= FAILSAFE_VALUE;
          r_valid <= 1'b0;
        end
      end
    end

    assign pwm_out[i*OUT_WIDTH +: OUT_WIDTH] = r_out;
    assign update[i]   = r_upd;
    assign ch_valid[i] = r_valid;
  end

  assign failsafe = ~(&ch_valid);

endmodule

// File: doc/pwm_capture_array.md
PWM_CAPTURE_ARRAY -- requirements
Module: pwm_capture_array

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent receiver PWM channels.
REQ-002 Parameter OUT_WIDTH, default 8: bits per channel result.
REQ-003 Parameter TICK_DIV, default 208: sys_clk cycles per measurement tick.
REQ-004 Parameter GLITCH_TICKS, default 64: high pulses shorter than this are rejected as noise.
REQ-005 Parameter MIN_TICKS, default 256: pulse width that maps to result 0 (1 ms nominal).
REQ-006 Parameter MAX_TICKS, default 512: pulse width that maps to full scale (2 ms nominal).
REQ-007 Parameter ABORT_TICKS, default 1024: high time at which a pulse is declared stuck and discarded.
REQ-008 Parameter TIMEOUT_TICKS, default 6400: ticks without an accepted pulse before failsafe (about 25 ms).
REQ-009 Parameter FAILSAFE_VALUE, default 0: OUT_WIDTH-bit value driven on a channel in failsafe.
REQ-010 sys_clk  input  1  sole clock; all state on rising edge.
REQ-011 sys_rst  input  1  reset, asynchronous, active-high.
REQ-012 pwm_in  input  NUM_CH  raw receiver PWM lines, asynchronous to sys_clk.
REQ-013 pwm_out  output  NUM_CH*OUT_WIDTH  packed results; channel n occupies bits [n*OUT_WIDTH +: OUT_WIDTH].
REQ-014 update  output  NUM_CH  one-cycle strobe per channel when its pwm_out slice loads a new measurement.
REQ-015 ch_valid  output  NUM_CH  channel has an accepted pulse more recent than TIMEOUT_TICKS.
REQ-016 failsafe  output  1  high when any ch_valid bit is low.

Function
REQ-017 Each pwm_in bit SHALL pass through a two-flop synchronizer; all edge detection uses the synchronized value and its one-cycle-delayed copy.
REQ-018 A single free-running prescaler SHALL count 0..TICK_DIV-1 and assert tick for one cycle when at TICK_DIV-1, then wrap to 0; it is shared by all channels.
REQ-019 Each channel SHALL run an independent FSM with states WAIT_LOW, ARMED, HIGH.
REQ-020 WAIT_LOW: go to ARMED when synchronized input is 0.
REQ-021 ARMED: on synchronized rising edge go to HIGH and clear high_count to 0.
REQ-022 HIGH: high_count increments by 1 on each tick; a tick in the same cycle as the falling edge is not counted.
REQ-023 HIGH, falling edge, high_count < GLITCH_TICKS: reject, no update, go to ARMED.
REQ-024 HIGH, falling edge, high_count >= GLITCH_TICKS: accept; result = 0 if high_count <= MIN_TICKS, else min(high_count - MIN_TICKS, 2^OUT_WIDTH - 1), saturating; go to ARMED.
REQ-025 HIGH, high_count reaches ABORT_TICKS: discard, no update, go to WAIT_LOW.
REQ-026 high_count SHALL be clog2(ABORT_TICKS+1) bits wide and never wrap.
REQ-027 On accept, the pwm_out slice and update bit SHALL change on the next sys_clk edge; update is high exactly one cycle; ch_valid goes 1 on the same edge.
REQ-028 Per-channel timeout counter SHALL increment on tick, saturate at TIMEOUT_TICKS, and clear to 0 on accept.
REQ-029 When the timeout counter reaches TIMEOUT_TICKS, ch_valid SHALL go 0 and the slice SHALL load FAILSAFE_VALUE, without asserting update.
REQ-030 If accept and timeout occur in the same cycle, accept SHALL win.
REQ-031 Channels SHALL be fully independent; simultaneous edges on several channels are each handled in the same cycle.

Reset
REQ-032 While sys_rst is high: prescaler, high_count and timeout counters are 0; FSMs are in WAIT_LOW; synchronizers are 0; pwm_out is FAILSAFE_VALUE in every slice; update and ch_valid are 0; failsafe is 1.
REQ-033 Reset asserted mid-pulse SHALL discard the pulse; a line already high at reset release SHALL NOT be measured until it has been seen low.

Verification
REQ-034 Channel 0 high for 384 ticks, low for 20 ms -> pwm_out[7:0]=128, update[0] for 1 cycle, ch_valid[0]=1.
REQ-035 High for 200 ticks -> result 0; high for 600 ticks -> result 255 (saturated); high for 30 ticks -> no update, output unchanged.
REQ-036 Line held high for 1100 ticks -> no update; a later 300-tick pulse is ignored until low is seen, then the next pulse gives 44.
REQ-037 After a valid pulse, no further pulses for 6400 ticks -> ch_valid[0]=0, slice=FAILSAFE_VALUE, failsafe=1, update stays 0.
REQ-038 Four channels with pulses of 256, 320, 448 and 512 ticks and coincident falling edges -> results 0, 64, 192, 255 with update=4'b1111 in the same cycle.
REQ-039 sys_rst pulsed during a 300-tick pulse -> no update from that pulse; all outputs match REQ-032 values.
